// File: rtl/dec_arb_pkg.sv
// Shared types and the round-robin search helper for the four-way grant arbiter.
package dec_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // Search last+1, last+2, last+3, last (mod NUM_REQ); optionally skip one index.
  function automatic pick_t rr_pick(
    input logic [NUM_REQ-1:0] req,
    input logic [ID_W-1:0]    last,
    input logic               exclude_en,
    input logic [ID_W-1:0]    exclude_id
  );
    pick_t           res;
    logic [ID_W-1:0] cand;
    res = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + ID_W'(i);
      if (!res.found && req[cand] && !(exclude_en && (cand == exclude_id))) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/encoder.sv
// 2-to-4 one-hot encoder with enable; output is all-zero when disabled.
module encoder
  import dec_arb_pkg::*;
(
  input  logic [ID_W-1:0]    din,
  input  logic               en,
  output logic [NUM_REQ-1:0] dout
);

  // NOTE: assigning a default first keeps this combinational block latch-free.
  always_comb begin
    dout = '0;
    if (en) dout[din] = 1'b1;
  end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Four-way round-robin arbiter with release/timeout handling; grant is the
// one-hot decode of the registered owner index through the shared encoder.
module dec_rr_arbiter
  import dec_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_vld,
  output logic               preempt
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              preempt_q, preempt_d;

  logic  owner_rel;
  pick_t pick_any;
  pick_t pick_oth;

  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    preempt_d = 1'b0;

    owner_rel = done[id_q] | ~req[id_q];
    pick_any  = rr_pick(req, last_q, 1'b0, '0);
    pick_oth  = rr_pick(req, last_q, 1'b1, id_q);

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_any.found) begin
          state_d = ST_GRANT;
          id_d    = pick_any.idx;
          last_d  = pick_any.idx;
        end
      end
      ST_GRANT: begin
        // A release wins over the hold limit, so no preempt pulse in that case.
        if (owner_rel) begin
          cnt_d = '0;
          if (pick_oth.found) begin
            id_d   = pick_oth.idx;
            last_d = pick_oth.idx;
          end else begin
            state_d = ST_IDLE;
          end
        end else if ((cnt_q == HOLD_LAST) && pick_oth.found) begin
          id_d      = pick_oth.idx;
          last_d    = pick_oth.idx;
          cnt_d     = '0;
          preempt_d = 1'b1;
        end else if (cnt_q != HOLD_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      last_q    <= ID_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign gnt_id  = id_q;
  assign gnt_vld = (state_q == ST_GRANT);
  assign preempt = preempt_q;

  encoder u_encoder (
    .din  (id_q),
    .en   (gnt_vld),
    .dout (gnt)
  );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Directed and randomized bench for dec_rr_arbiter against a cycle-count
// reference model of the round-robin / release / hold-limit rules.
module tb_dec_rr_arbiter;

  localparam int HOLD_MAX = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_vld;
  logic       preempt;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner index, cycles held so far, most recent grant.
  bit m_vld;
  bit m_pre;
  bit m_id_known;
  int m_owner;
  int m_last;
  int m_held;

  dec_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int next_owner(input logic [3:0] r, input int from, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int j;
      j = (from + k) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [3:0] r, input logic [3:0] d, input logic rn);
    int nxt;
    if (!rn) begin
      m_vld = 0; m_pre = 0; m_owner = 0; m_last = 3; m_held = 0; m_id_known = 1;
      return;
    end
    m_pre = 0;
    if (!m_vld) begin
      nxt = next_owner(r, m_last, -1);
      if (nxt >= 0) begin
        m_vld = 1; m_owner = nxt; m_last = nxt; m_held = 1;
      end
    end else begin
      nxt = next_owner(r, m_last, m_owner);
      if (d[m_owner] || !r[m_owner]) begin
        if (nxt >= 0) begin
          m_owner = nxt; m_last = nxt; m_held = 1;
        end else begin
          m_vld = 0; m_held = 0; m_id_known = 0;
        end
      end else if (m_held >= HOLD_MAX && nxt >= 0) begin
        m_owner = nxt; m_last = nxt; m_held = 1; m_pre = 1;
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic compare_all();
    check("gnt_vld", 32'(gnt_vld), 32'(m_vld));
    check("gnt", 32'(gnt), m_vld ? (32'd1 << m_owner) : 32'd0);
    check("preempt", 32'(preempt), 32'(m_pre));
    check("onehot", 32'($countones(gnt)), 32'(gnt_vld));
    if (m_vld || m_id_known) check("gnt_id", 32'(gnt_id), 32'(m_owner));
  endtask

  task automatic cycle(input logic [3:0] r, input logic [3:0] d, input logic rn);
    req = r; done = d; rst_n = rn;
    model_step(r, d, rn);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    int         n_pre;
    logic [3:0] r;
    logic [3:0] d;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_n = 1'b0; req = '0; done = '0;
    m_vld = 0; m_pre = 0; m_owner = 0; m_last = 3; m_held = 0; m_id_known = 1;

    // Reset then idle with no requests.
    cycle(4'h0, 4'h0, 1'b0);
    cycle(4'h0, 4'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(4'h0, 4'h0, 1'b1);
      check("idle_gnt", 32'(gnt), 32'd0);
      check("idle_id", 32'(gnt_id), 32'd0);
    end

    // All requesting, each owner releases on its second cycle.
    cycle(4'hF, 4'h0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("rr_first", 32'(gnt), 32'(exp_seq[k]));
      cycle(4'hF, 4'h0, 1'b1);
      check("rr_second", 32'(gnt), 32'(exp_seq[k]));
      cycle(4'hF, 4'(1 << (k % 4)), 1'b1);
    end
    cycle(4'h0, 4'h0, 1'b0);

    // Lone requester is never preempted.
    for (int i = 0; i < 20; i++) begin
      cycle(4'b0100, 4'h0, 1'b1);
      check("solo_gnt", 32'(gnt), 32'b0100);
      check("solo_pre", 32'(preempt), 32'd0);
    end
    cycle(4'h0, 4'h0, 1'b0);

    // Two contenders, no release: rotation by hold limit.
    cycle(4'b0011, 4'h0, 1'b1);
    n_pre = 0;
    for (int t = 0; t <= 16; t++) begin
      check("hold_gnt", 32'(gnt), (t < 8) ? 32'b0001 : (t < 16) ? 32'b0010 : 32'b0001);
      check("hold_pre", 32'(preempt), 32'(t == 8 || t == 16));
      if (preempt) n_pre++;
      if (t < 16) cycle(4'b0011, 4'h0, 1'b1);
    end
    check("hold_npre", 32'(n_pre), 32'd2);
    cycle(4'h0, 4'h0, 1'b0);

    // Release coincides with hold limit; non-owner done ignored.
    cycle(4'b0010, 4'h0, 1'b1);
    for (int t = 0; t < 7; t++) begin
      cycle(4'b0010, (t == 3) ? 4'b1000 : 4'b0000, 1'b1);
      check("nonown_gnt", 32'(gnt), 32'b0010);
    end
    cycle(4'b0110, 4'b1010, 1'b1);
    check("relhold_gnt", 32'(gnt), 32'b0100);
    check("relhold_pre", 32'(preempt), 32'd0);

    // Reset during a grant to requester 2.
    cycle(4'b0100, 4'h0, 1'b1);
    check("pre_rst_gnt", 32'(gnt), 32'b0100);
    cycle(4'b0100, 4'h0, 1'b0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_vld", 32'(gnt_vld), 32'd0);
    check("rst_id", 32'(gnt_id), 32'd0);
    check("rst_pre", 32'(preempt), 32'd0);
    cycle(4'b0101, 4'h0, 1'b1);
    check("post_rst_gnt", 32'(gnt), 32'b0001);

    // Randomized traffic with slowly changing requests to reach the hold limit.
    r = 4'h0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) r = 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      cycle(r, d, ($urandom_range(0, 149) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
